// File: rtl/rotation_result_fifo_pkg.sv
// Shared types and sizing for the rotation-mode CORDIC result path.
package rotation_result_fifo_pkg;

  localparam int JACOBI_OUTPUT_WORD_WIDTH = 16;
  localparam int JACOBI_ROT_FIFO_DEPTH    = 8;

  typedef struct packed {
    logic [JACOBI_OUTPUT_WORD_WIDTH-1:0] x;
    logic [JACOBI_OUTPUT_WORD_WIDTH-1:0] y;
    logic [JACOBI_OUTPUT_WORD_WIDTH-1:0] z;
  } cordic_triplet_t;

endpackage

// File: rtl/rotation_result_fifo.sv
// FWFT FIFO for rotation CORDIC x/y/z triplets; the source cannot stall, so
// level/afull let the controller throttle issues and overflow flags any loss.
module rotation_result_fifo
  import rotation_result_fifo_pkg::*;
#(
  parameter int WIDTH       = JACOBI_OUTPUT_WORD_WIDTH,
  parameter int DEPTH       = JACOBI_ROT_FIFO_DEPTH,
  parameter int AFULL_LEVEL = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         in_x_i,
  input  logic [WIDTH-1:0]         in_y_i,
  input  logic [WIDTH-1:0]         in_z_i,
  input  logic                     in_vld_i,
  output logic [WIDTH-1:0]         out_x_o,
  output logic [WIDTH-1:0]         out_y_o,
  output logic [WIDTH-1:0]         out_z_o,
  output logic                     out_vld_o,
  input  logic                     out_rdy_i,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     afull_o,
  output logic                     full_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] z;
  } trip_t;

  trip_t [DEPTH-1:0] mem_q;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              full, push, pop;

  // Pop qualifies only on registered state, so out_rdy_i never reaches out_vld_o.
  assign full = (level_q == PW'(DEPTH));
  assign pop  = (level_q != '0) && out_rdy_i;
  assign push = in_vld_i && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
      if (in_vld_i && !push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Flush leaves storage intact; only the pointers are rewound.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
    end else if (push && !flush_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= '{x: in_x_i, y: in_y_i, z: in_z_i};
    end
  end

  assign out_x_o    = mem_q[rd_ptr_q[AW-1:0]].x;
  assign out_y_o    = mem_q[rd_ptr_q[AW-1:0]].y;
  assign out_z_o    = mem_q[rd_ptr_q[AW-1:0]].z;
  assign out_vld_o  = (level_q != '0);
  assign level_o    = level_q;
  assign afull_o    = (level_q >= PW'(AFULL_LEVEL));
  assign full_o     = full;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_rotation_result_fifo.sv
// Directed bench for rotation_result_fifo: vector table plus wrap/reset sequences.
module tb_rotation_result_fifo;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush_i;
  logic [W-1:0] in_x_i, in_y_i, in_z_i;
  logic         in_vld_i;
  logic [W-1:0] out_x_o, out_y_o, out_z_o;
  logic         out_vld_o;
  logic         out_rdy_i;
  logic [3:0]   level_o;
  logic         afull_o, full_o, overflow_o;

  int n_chk  = 0;
  int n_fail = 0;

  rotation_result_fifo #(.WIDTH(W), .DEPTH(8), .AFULL_LEVEL(6)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_x_i(in_x_i), .in_y_i(in_y_i), .in_z_i(in_z_i), .in_vld_i(in_vld_i),
    .out_x_o(out_x_o), .out_y_o(out_y_o), .out_z_o(out_z_o),
    .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i), .level_o(level_o),
    .afull_o(afull_o), .full_o(full_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         fl, vld, rdy;
    logic [W-1:0] x, y, z;
    logic         e_vld, e_af, e_full, e_ovf;
    int           e_lvl;
    logic [W-1:0] ex, ey, ez;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected flags follow from the hand-entered level (AFULL_LEVEL=6, DEPTH=8).
  task automatic add(input logic fl, input logic vld, input int x, input int y, input int z,
                     input logic rdy, input int lvl, input logic ovf,
                     input int ex, input int ey, input int ez);
    vec_t v;
    v.fl = fl; v.vld = vld; v.rdy = rdy;
    v.x = W'(x); v.y = W'(y); v.z = W'(z);
    v.e_lvl = lvl; v.e_vld = (lvl != 0); v.e_af = (lvl >= 6); v.e_full = (lvl == 8);
    v.e_ovf = ovf; v.ex = W'(ex); v.ey = W'(ey); v.ez = W'(ez);
    tbl.push_back(v);
  endtask

  task automatic step(input logic fl, input logic v, input int x, input int y, input int z,
                      input logic r);
    flush_i = fl; in_vld_i = v; out_rdy_i = r;
    in_x_i = W'(x); in_y_i = W'(y); in_z_i = W'(z);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_i = 1'b0; in_vld_i = 1'b0; out_rdy_i = 1'b0;
  endtask

  int q[$];

  initial begin
    rst = 1'b0;
    flush_i = 1'b0; in_vld_i = 1'b0; out_rdy_i = 1'b0;
    in_x_i = '0; in_y_i = '0; in_z_i = '0;
    #2;
    chk("rst_vld",   out_vld_o,  0);
    chk("rst_lvl",   level_o,    0);
    chk("rst_full",  full_o,     0);
    chk("rst_afull", afull_o,    0);
    chk("rst_ovf",   overflow_o, 0);
    chk("rst_x",     out_x_o,    0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Basic FWFT and in-order pop
    add(0,1,1,2,3,0, 1,0, 1,2,3);
    add(0,1,4,5,6,0, 2,0, 1,2,3);
    add(0,0,0,0,0,1, 1,0, 4,5,6);
    add(0,0,0,0,0,1, 0,0, 0,0,0);
    // Push+pop into empty: only the push happens
    add(0,1,7,7,7,1, 1,0, 7,7,7);
    add(0,0,0,0,0,1, 0,0, 0,0,0);
    // Fill to full, then overflow with 99
    for (int v = 1; v <= 8; v++) add(0,1,v,v+100,v+200,0, v,0, 1,101,201);
    add(0,1,99,99,99,0, 8,1, 1,101,201);
    for (int k = 1; k <= 7; k++) add(0,0,0,0,0,1, 8-k,1, k+1,k+101,k+201);
    add(0,0,0,0,0,1, 0,1, 0,0,0);
    // Flush with contents and overflow set; push/pop in the flush cycle ignored
    add(0,1,11,0,0,0, 1,1, 11,0,0);
    add(0,1,12,0,0,0, 2,1, 11,0,0);
    add(1,1,13,0,0,1, 0,0, 0,0,0);
    add(0,1,5,0,0,0, 1,0, 5,0,0);

    foreach (tbl[i]) begin
      step(tbl[i].fl, tbl[i].vld, tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].rdy);
      chk($sformatf("v%0d_vld", i),   out_vld_o,  tbl[i].e_vld);
      chk($sformatf("v%0d_lvl", i),   level_o,    tbl[i].e_lvl);
      chk($sformatf("v%0d_afull", i), afull_o,    tbl[i].e_af);
      chk($sformatf("v%0d_full", i),  full_o,     tbl[i].e_full);
      chk($sformatf("v%0d_ovf", i),   overflow_o, tbl[i].e_ovf);
      if (tbl[i].e_vld) begin
        chk($sformatf("v%0d_x", i), out_x_o, tbl[i].ex);
        chk($sformatf("v%0d_y", i), out_y_o, tbl[i].ey);
        chk($sformatf("v%0d_z", i), out_z_o, tbl[i].ez);
      end
    end

    // Drain (5,0,0), refill to full, then stream 20 push+pop cycles across the wrap
    step(0,0,0,0,0,1);
    chk("drain_lvl", level_o, 0);
    for (int v = 0; v < 8; v++) begin
      step(0,1,200+v,300+v,400+v,0);
      q.push_back(200+v);
    end
    chk("fill_full", full_o, 1);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("s%0d_head_pre", i), out_x_o, q[0]);
      step(0,1,100+i,101+i,102+i,1);
      void'(q.pop_front());
      q.push_back(100+i);
      chk($sformatf("s%0d_lvl", i),  level_o,    8);
      chk($sformatf("s%0d_ovf", i),  overflow_o, 0);
      chk($sformatf("s%0d_head", i), out_x_o,    q[0]);
    end
    // Drain 5 -> 3 remain, heads 117..119
    for (int i = 0; i < 5; i++) begin
      step(0,0,0,0,0,1);
      void'(q.pop_front());
    end
    idle();
    chk("pre_rst_lvl",  level_o, 3);
    chk("pre_rst_head", out_x_o, q[0]);
    chk("pre_rst_y",    out_y_o, q[0] + 1);

    // Asynchronous reset mid-cycle, checked before the next edge
    #2 rst = 1'b0;
    #1;
    chk("arst_vld", out_vld_o, 0);
    chk("arst_lvl", level_o,   0);
    chk("arst_x",   out_x_o,   0);
    chk("arst_ovf", overflow_o, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_vld", out_vld_o, 0);
    step(0,1,42,43,44,0);
    idle();
    chk("post_rst_lvl", level_o, 1);
    chk("post_rst_x",   out_x_o, 42);
    chk("post_rst_z",   out_z_o, 44);
    step(0,0,0,0,0,0);
    chk("post_rst_hold", level_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rotation_result_fifo.md
Name: rotation_result_fifo

Overview:
- Buffers x/y/z result triplets from the rotation-mode CORDIC. The CORDIC has valid-only output and no backpressure.
- Presents the triplets to jacobi_main_controller through a valid/ready interface, first-word-fall-through.
- Drives level and almost-full indications so the controller throttles new rotation issues before the FIFO can overflow.
- Sits between rotation_cordic and main_controller, on the rotation_fifo_out_* path in jacobi_top.

Parameters:
- WIDTH, JACOBI_OUTPUT_WORD_WIDTH, width of each of x, y, z.
- DEPTH, 8, number of triplet entries; must be a power of two, minimum 2.
- AFULL_LEVEL, DEPTH-2, occupancy at or above which afull_o asserts.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous clear of contents and flags.
- in_x_i  in  WIDTH  rotation CORDIC x result.
- in_y_i  in  WIDTH  rotation CORDIC y result.
- in_z_i  in  WIDTH  rotation CORDIC z result.
- in_vld_i  in  1  triplet valid; there is no ready, so the source never stalls.
- out_x_o  out  WIDTH  head entry x.
- out_y_o  out  WIDTH  head entry y.
- out_z_o  out  WIDTH  head entry z.
- out_vld_o  out  1  head entry valid (FIFO non-empty).
- out_rdy_i  in  1  consumer accepts the head entry.
- level_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- afull_o  out  1  level_o >= AFULL_LEVEL.
- full_o  out  1  level_o == DEPTH.
- overflow_o  out  1  sticky: a triplet was dropped.

Behaviour:
- Reset (rst low, asynchronous):
  - Pointers, level and all storage entries clear to 0.
  - out_vld_o=0, full_o=0, afull_o=0 (unless AFULL_LEVEL==0), overflow_o=0, out_x/y/z_o=0.
- Storage: DEPTH-entry register array of packed {x,y,z}.
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty.
  - Index wraps modulo DEPTH.
- Push: in_vld_i=1 and (not full, or pop in the same cycle). The entry is written at wr_ptr and wr_ptr increments.
- Pop: out_vld_o=1 and out_rdy_i=1. rd_ptr increments.
- Level update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - neither: unchanged.
- FWFT: out_x/y/z_o are a combinational read of storage[rd_ptr].
  - A push into an empty FIFO gives out_vld_o=1 on the next cycle with that data (latency 1).
  - out_vld_o is high exactly while level_o != 0.
- Data while out_vld_o=0: the value is the last-read or stale entry. The bench does not check it.
- Simultaneous push and pop when full: both take effect, level stays DEPTH, and nothing is dropped.
- Simultaneous push and pop when empty: the pop does not occur (out_vld_o=0) and the push is accepted.
- Push when full with no pop:
  - The triplet is discarded and storage is unchanged.
  - overflow_o sets on the next edge and stays high until flush_i or reset.
- flush_i=1: on the next edge, pointers, level and overflow_o clear to 0.
  - Storage contents are not cleared.
  - Any push or pop in that cycle is ignored.
- Flags full_o, afull_o and out_vld_o derive from registered pointers and level only. No combinational path exists from in_vld_i to any output.
- Combinational path from out_rdy_i: none to out_vld_o within the same cycle.
- Reset asserted mid-stream: all state clears immediately. After rst deasserts, the first accepted push is the new head.
- Data passes through unmodified, with no width conversion and no sign handling.

Decomposition:
- common package additions:
  - JACOBI_ROT_FIFO_DEPTH (default 8).
  - Packed struct typedef cordic_triplet_t {x,y,z} of JACOBI_OUTPUT_WORD_WIDTH each, also used by main_controller.
- Single module; no sub-module. Pointer/level logic and storage live in the same file.

Test Plan:
- Reset, then push triplets (1,2,3), (4,5,6), out_rdy_i=0 -> out_vld_o=1 one cycle after the first push, head=(1,2,3), level_o=2. Raise out_rdy_i -> pops in order, then out_vld_o=0, level_o=0.
- DEPTH=8, AFULL_LEVEL=6, push 8 with no pop:
  - afull_o asserts when level_o reaches 6.
  - full_o asserts at 8.
  - A 9th push (value 99) -> overflow_o=1 and level_o stays 8.
  - Drain yields values 1..8 only.
- Full FIFO with continuous push and pop for 20 cycles (values 100..119) -> level_o stays 8, overflow_o stays 0, and output order is correct across pointer wrap.
- Empty FIFO, in_vld_i and out_rdy_i both high in the same cycle with (7,7,7) -> level_o=1 next cycle, head=(7,7,7).
- overflow_o set, then flush_i pulse -> next cycle level_o=0, out_vld_o=0, overflow_o=0. A subsequent push of (5,0,0) becomes the head.
- rst low asynchronously mid-stream with 3 entries -> outputs clear without waiting for a clock edge. After release, the FIFO is empty and accepts new data.
